// File: rtl/sram_port_arbiter.sv
// Serialises record-path writes and playback-path reads onto one external SRAM.
// Ack K+1 cycles after an idle-cycle grant; requesters hold their request until ack, so a losing port simply waits.
module sram_port_arbiter #(
  parameter int ACCESS_CYCLES = 2,
  parameter bit WR_PRIORITY   = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_wr_req,
  input  logic [19:0] i_wr_addr,
  input  logic [15:0] i_wr_data,
  output logic        o_wr_ack,
  input  logic        i_rd_req,
  input  logic [19:0] i_rd_addr,
  output logic [15:0] o_rd_data,
  output logic        o_rd_ack,
  output logic [19:0] o_sram_addr,
  output logic [15:0] o_sram_dq,
  output logic        o_sram_dq_oe,
  input  logic [15:0] i_sram_dq,
  output logic        o_sram_we_n,
  output logic        o_sram_oe_n,
  output logic        o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_ACK} state_t;

  localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        op_wr, op_wr_nxt;
  logic        last_wr, last_wr_nxt;
  logic [19:0] addr_nxt;
  logic [15:0] dq_nxt, rd_data_nxt;
  logic        dq_oe_nxt, we_n_nxt, oe_n_nxt, wr_ack_nxt, rd_ack_nxt;
  logic        grant_wr;

  // Write wins a tie under fixed priority, or when read was served last.
  assign grant_wr = i_wr_req & (~i_rd_req | WR_PRIORITY | ~last_wr);
  assign o_busy   = (state != S_IDLE);

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    op_wr_nxt   = op_wr;
    last_wr_nxt = last_wr;
    addr_nxt    = o_sram_addr;
    dq_nxt      = o_sram_dq;
    rd_data_nxt = o_rd_data;
    dq_oe_nxt   = o_sram_dq_oe;
    we_n_nxt    = o_sram_we_n;
    oe_n_nxt    = o_sram_oe_n;
    wr_ack_nxt  = 1'b0;
    rd_ack_nxt  = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_wr_req || i_rd_req) begin
          state_nxt = S_ACCESS;
          cnt_nxt   = 4'd0;
          op_wr_nxt = grant_wr;
          addr_nxt  = grant_wr ? i_wr_addr : i_rd_addr;
          if (grant_wr) dq_nxt = i_wr_data;
          we_n_nxt  = ~grant_wr;
          oe_n_nxt  = grant_wr;
          dq_oe_nxt = grant_wr;
        end
      end
      S_ACCESS: begin
        cnt_nxt = cnt + 4'd1;
        if (cnt == LAST_CNT) begin
          state_nxt   = S_ACK;
          we_n_nxt    = 1'b1;
          oe_n_nxt    = 1'b1;
          wr_ack_nxt  = op_wr;
          rd_ack_nxt  = ~op_wr;
          last_wr_nxt = op_wr;
          if (!op_wr) rd_data_nxt = i_sram_dq;
        end
      end
      S_ACK: begin
        // Data drive was held through the ack cycle for write hold time.
        state_nxt = S_IDLE;
        dq_oe_nxt = 1'b0;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= S_IDLE;
      cnt          <= 4'd0;
      op_wr        <= 1'b0;
      last_wr      <= 1'b0;
      o_sram_addr  <= 20'd0;
      o_sram_dq    <= 16'd0;
      o_rd_data    <= 16'd0;
      o_sram_dq_oe <= 1'b0;
      o_sram_we_n  <= 1'b1;
      o_sram_oe_n  <= 1'b1;
      o_wr_ack     <= 1'b0;
      o_rd_ack     <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      op_wr        <= op_wr_nxt;
      last_wr      <= last_wr_nxt;
      o_sram_addr  <= addr_nxt;
      o_sram_dq    <= dq_nxt;
      o_rd_data    <= rd_data_nxt;
      o_sram_dq_oe <= dq_oe_nxt;
      o_sram_we_n  <= we_n_nxt;
      o_sram_oe_n  <= oe_n_nxt;
      o_wr_ack     <= wr_ack_nxt;
      o_rd_ack     <= rd_ack_nxt;
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Random requesters on two arbiter configurations (K=2 round-robin, K=1 write-priority)
// checked cycle by cycle against a slot-level schedule model and an SRAM memory model.
module tb_sram_port_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        sel = 1'b0;
  logic        wr_req = 1'b0, rd_req = 1'b0;
  logic [19:0] wr_addr = '0, rd_addr = '0;
  logic [15:0] wr_data = '0;
  logic [15:0] sram_in;

  always #5 i_clk = ~i_clk;

  logic        wr_ack_a, rd_ack_a, dq_oe_a, we_n_a, oe_n_a, busy_a;
  logic        wr_ack_b, rd_ack_b, dq_oe_b, we_n_b, oe_n_b, busy_b;
  logic [15:0] rd_data_a, dq_a, rd_data_b, dq_b;
  logic [19:0] addr_a, addr_b;

  sram_port_arbiter #(.ACCESS_CYCLES(2), .WR_PRIORITY(1'b0)) dut_a (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_wr_req(wr_req & ~sel), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .o_wr_ack(wr_ack_a),
    .i_rd_req(rd_req & ~sel), .i_rd_addr(rd_addr), .o_rd_data(rd_data_a), .o_rd_ack(rd_ack_a),
    .o_sram_addr(addr_a), .o_sram_dq(dq_a), .o_sram_dq_oe(dq_oe_a), .i_sram_dq(sram_in),
    .o_sram_we_n(we_n_a), .o_sram_oe_n(oe_n_a), .o_busy(busy_a));

  sram_port_arbiter #(.ACCESS_CYCLES(1), .WR_PRIORITY(1'b1)) dut_b (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_wr_req(wr_req & sel), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .o_wr_ack(wr_ack_b),
    .i_rd_req(rd_req & sel), .i_rd_addr(rd_addr), .o_rd_data(rd_data_b), .o_rd_ack(rd_ack_b),
    .o_sram_addr(addr_b), .o_sram_dq(dq_b), .o_sram_dq_oe(dq_oe_b), .i_sram_dq(sram_in),
    .o_sram_we_n(we_n_b), .o_sram_oe_n(oe_n_b), .o_busy(busy_b));

  logic        wr_ack, rd_ack, dq_oe, we_n, oe_n, busy;
  logic [15:0] rd_data, dq;
  logic [19:0] addr;
  assign wr_ack  = sel ? wr_ack_b  : wr_ack_a;
  assign rd_ack  = sel ? rd_ack_b  : rd_ack_a;
  assign dq_oe   = sel ? dq_oe_b   : dq_oe_a;
  assign we_n    = sel ? we_n_b    : we_n_a;
  assign oe_n    = sel ? oe_n_b    : oe_n_a;
  assign busy    = sel ? busy_b    : busy_a;
  assign rd_data = sel ? rd_data_b : rd_data_a;
  assign dq      = sel ? dq_b      : dq_a;
  assign addr    = sel ? addr_b    : addr_a;

  // SRAM: 8 words addressed by the low address bits, preset to a pattern while in reset.
  logic [15:0] mem [0:7];
  always @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < 8; i++) mem[i] <= 16'hC000 + 16'(i);
    end else if (!we_n) begin
      mem[addr[2:0]] <= dq;
    end
  end
  assign sram_in = !oe_n ? mem[addr[2:0]] : 16'hDEAD;

  // Reference model: one access slot at a time, described by its start cycle.
  int          n_cmp = 0, n_bad = 0;
  int          cyc, s_start, free_at;
  bit          cur_wr, last_wr;
  logic [2:0]  cur_idx;
  logic [15:0] cur_data, exp_dq, exp_rd;
  logic [19:0] exp_addr;
  logic [15:0] ref_mem [0:7];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d (sel %0d): got %0h, expected %0h", tag, cyc, sel, obs, exp);
    end
  endtask

  task automatic model_reset();
    s_start = -1; free_at = 0; cyc = 0; last_wr = 1'b0;
    exp_addr = '0; exp_dq = '0; exp_rd = '0;
    for (int i = 0; i < 8; i++) ref_mem[i] = 16'hC000 + 16'(i);
  endtask

  task automatic do_reset(input bit s);
    i_rst = 1'b1; wr_req = 1'b0; rd_req = 1'b0; sel = s;
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    model_reset();
  endtask

  task automatic run(input int n, input int wr_pct, input int rd_pct, input bit arm_rst);
    int  k;
    bit  prio, in_acc, in_ack, g, armed;
    k = sel ? 1 : 2;
    prio = sel;
    armed = arm_rst;
    for (int i = 0; i < n; i++) begin
      in_acc = (s_start >= 0) && (cyc >= s_start + 1) && (cyc <= s_start + k);
      in_ack = (s_start >= 0) && (cyc == s_start + k + 1);
      if (in_ack && !cur_wr) exp_rd = ref_mem[cur_idx];
      chk("we_n",    we_n,    !(in_acc && cur_wr));
      chk("oe_n",    oe_n,    !(in_acc && !cur_wr));
      chk("dq_oe",   dq_oe,   cur_wr && (in_acc || in_ack));
      chk("wr_ack",  wr_ack,  in_ack && cur_wr);
      chk("rd_ack",  rd_ack,  in_ack && !cur_wr);
      chk("busy",    busy,    in_acc || in_ack);
      chk("addr",    addr,    exp_addr);
      chk("dq",      dq,      exp_dq);
      chk("rd_data", rd_data, exp_rd);
      if (in_ack && cur_wr) ref_mem[cur_idx] = cur_data;

      // Requesters drop on the edge after ack and may re-raise at once.
      if (wr_req && wr_ack) wr_req = 1'b0;
      if (rd_req && rd_ack) rd_req = 1'b0;
      if (!wr_req && $urandom_range(99) < wr_pct) begin
        wr_req = 1'b1; wr_addr = {17'($urandom), 3'($urandom)}; wr_data = 16'($urandom);
      end
      if (!rd_req && $urandom_range(99) < rd_pct) begin
        rd_req = 1'b1; rd_addr = {17'($urandom), 3'($urandom)};
      end

      if (cyc >= free_at && (wr_req || rd_req)) begin
        g = wr_req && (!rd_req || prio || !last_wr);
        s_start = cyc; cur_wr = g; last_wr = g;
        exp_addr = g ? wr_addr : rd_addr;
        cur_idx = exp_addr[2:0];
        if (g) begin cur_data = wr_data; exp_dq = wr_data; end
        free_at = cyc + k + 2;
      end

      if (armed && s_start >= 0 && cur_wr && cyc == s_start + 2) begin
        armed = 1'b0;
        i_rst = 1'b1;
        #1;
        chk("rst_we_n",    we_n,    1'b1);
        chk("rst_oe_n",    oe_n,    1'b1);
        chk("rst_dq_oe",   dq_oe,   1'b0);
        chk("rst_addr",    addr,    20'd0);
        chk("rst_dq",      dq,      16'd0);
        chk("rst_rd_data", rd_data, 16'd0);
        chk("rst_busy",    busy,    1'b0);
        chk("rst_wr_ack",  wr_ack,  1'b0);
        wr_req = 1'b0; rd_req = 1'b0;
        @(negedge i_clk);
        chk("rst_no_ack", wr_ack, 1'b0);
        i_rst = 1'b0;
        model_reset();
        cyc = -1;
      end else begin
        @(negedge i_clk);
      end
      cyc++;
    end
  endtask

  initial begin
    // K=2 round-robin: single write, then single read of the same word.
    do_reset(1'b0);
    wr_req = 1'b1; wr_addr = 20'h00010; wr_data = 16'hBEEF;
    run(8, 0, 0, 1'b0);
    rd_req = 1'b1; rd_addr = 20'h00020;
    run(8, 0, 0, 1'b0);
    chk("read_back", rd_data, 16'hBEEF);

    // Both requests held from reset: strict alternation starting with write.
    do_reset(1'b0);
    wr_req = 1'b1; rd_req = 1'b1;
    run(40, 100, 100, 1'b0);
    run(10, 0, 0, 1'b0);

    // Random traffic with a reset landing in the middle of a write.
    do_reset(1'b0);
    run(800, 35, 35, 1'b1);
    run(800, 60, 60, 1'b0);

    // K=1 write priority: reads starve while writes are held, then complete.
    do_reset(1'b1);
    wr_req = 1'b1; rd_req = 1'b1;
    run(30, 100, 100, 1'b0);
    run(15, 0, 100, 1'b0);
    run(800, 40, 50, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares the single external 16-bit SRAM between two requesters: the record path (write port, fed by the ADC/DSP) and the playback path (read port, feeding the DAC).
- Serialises accesses, generates SRAM_WE_N/SRAM_OE_N/address/data-drive timing, and returns a one-cycle ack per completed access.
- Sits between the top-level sequencer's data movers and the SRAM pins; the top level owns the tristate buffer, built from o_sram_dq and o_sram_dq_oe.

Parameters:
- ACCESS_CYCLES, 2, clock cycles that WE_N/OE_N are held active per access; legal range 1..15.
- WR_PRIORITY, 0, 0 = round-robin on simultaneous requests; 1 = write always wins a tie.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  asynchronous, active-high reset
- i_wr_req  in  1  write request; held high until o_wr_ack
- i_wr_addr  in  20  write address; stable while i_wr_req is high
- i_wr_data  in  16  write data; stable while i_wr_req is high
- o_wr_ack  out  1  one-cycle pulse: write completed
- i_rd_req  in  1  read request; held high until o_rd_ack
- i_rd_addr  in  20  read address; stable while i_rd_req is high
- o_rd_data  out  16  last read word; valid from the o_rd_ack cycle until the next read completes
- o_rd_ack  out  1  one-cycle pulse: read completed
- o_sram_addr  out  20  SRAM address (registered)
- o_sram_dq  out  16  SRAM write data (registered)
- o_sram_dq_oe  out  1  1 = top level drives SRAM_DQ
- i_sram_dq  in  16  SRAM_DQ input path
- o_sram_we_n  out  1  SRAM write enable, active low
- o_sram_oe_n  out  1  SRAM output enable, active low
- o_busy  out  1  high in S_ACCESS and S_ACK

Behaviour:
- Reset values (asynchronous, immediate):
  - state = S_IDLE, counter = 0, last_served = READ.
  - o_sram_we_n = 1, o_sram_oe_n = 1, o_sram_dq_oe = 0.
  - o_sram_addr = 0, o_sram_dq = 0, o_rd_data = 0.
  - o_wr_ack = 0, o_rd_ack = 0, o_busy = 0.
- States:
  - S_IDLE:
    - Samples both requests every cycle.
    - On any request: latch the winner's address (and data for a write) into o_sram_addr/o_sram_dq, record the op, clear the counter, go to S_ACCESS.
  - S_ACCESS (exactly ACCESS_CYCLES cycles):
    - Write: o_sram_we_n = 0, o_sram_dq_oe = 1.
    - Read: o_sram_oe_n = 0, o_sram_dq_oe = 0.
    - The counter increments each cycle. At the clock edge ending the last cycle: for a read, capture i_sram_dq into o_rd_data; go to S_ACK.
  - S_ACK (1 cycle):
    - Pulse the winner's ack; update last_served.
    - we_n and oe_n return to 1.
    - o_sram_addr is held; o_sram_dq_oe stays 1 for a write (hold time).
    - Go to S_IDLE.
- Arbitration (in S_IDLE only):
  - If only one request is high, it wins.
  - If both are high and WR_PRIORITY = 1, write wins.
  - If both are high and WR_PRIORITY = 0, the port that is not last_served wins. After reset, last_served = READ, so the first tie goes to write.
- Latency: a request first sampled in S_IDLE at cycle 0 occupies cycles 1..K in S_ACCESS and is acked in cycle K+1 (K = ACCESS_CYCLES). The next access can start at cycle K+2.
- Handshake rules:
  - The requester drops its request on the edge after seeing ack.
  - A request still high in the S_IDLE cycle after ack is treated as a new request.
  - Requests are never sampled in S_ACCESS or S_ACK; a request arriving then waits.
  - A request dropped before its ack is a protocol violation. The block does not detect it; the granted access still completes and acks.
- Starvation bound (WR_PRIORITY = 0): a continuously held request is served within two access slots (2*(K+2) cycles).
- o_sram_addr and o_sram_dq hold their last values while idle; no glitch on WE_N/OE_N, since both are registered.
- Reset mid-access:
  - All outputs go to reset values immediately and the access is abandoned; no ack is issued.
  - o_rd_data is cleared; the requester must re-request after reset.

Test Plan:
- Single write, K=2: wr_req with addr=0x00010, data=0xBEEF at cycle 0 -> we_n low in cycles 1-2 with addr=0x00010 and dq=0xBEEF, dq_oe high in cycles 1-3, o_wr_ack high only in cycle 3.
- Single read, K=2: rd_req addr=0x00020, SRAM model returns 0x1234 -> oe_n low in cycles 1-2, o_rd_data=0x1234 and o_rd_ack high in cycle 3, dq_oe=0 throughout.
- Simultaneous requests from reset, WR_PRIORITY=0, both held -> write served first (ack cycle 3), read starts cycle 5 (ack cycle 7), then write again; strict alternation.
- WR_PRIORITY=1, both requests held continuously -> only writes are served, o_rd_ack never pulses; release wr_req -> read acked K+1 cycles after its first S_IDLE sample.
- Reset asserted in cycle 2 of a write -> we_n=1, dq_oe=0, addr=0 in the same cycle, no o_wr_ack; after release a re-request completes normally.
- K=1 back-to-back reads at addrs 0,1,2 -> acks at cycles 2, 5, 8 with the correct data each.
